// File: rtl/seven_seg_pkg.sv
// Shared 7-segment helpers: digit patterns {A..G} and output polarity handling,
// usable by any display block that drives a common-anode or common-cathode part.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b111_1110;
      4'd1:    return 7'b011_0000;
      4'd2:    return 7'b110_1101;
      4'd3:    return 7'b111_1001;
      4'd4:    return 7'b011_0011;
      4'd5:    return 7'b101_1011;
      4'd6:    return 7'b101_1111;
      4'd7:    return 7'b111_0000;
      4'd8:    return 7'b111_1111;
      4'd9:    return 7'b111_1011;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Map a lit-high segment vector to the pad level the display expects.
  function automatic logic [7:0] drive_level(input logic [7:0] lit, input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter; carry_out doubles as the borrow when counting down.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  input  logic       up,
  input  logic       carry_in,
  output logic [3:0] value,
  output logic       carry_out
);

  assign carry_out = carry_in & (up ? (value == 4'd9) : (value == 4'd0));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= 4'd0;
    end else if (step && carry_in) begin
      if (up) value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
      else    value <= (value == 4'd0) ? 4'd9 : value - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_mux_display.sv
// Prescaled up/down BCD counter with a time-multiplexed 7-segment scan output,
// leading-zero blanking and a decimal-point pause indicator on digit 0.
module bcd_counter_mux_display
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 100_000_000,
  parameter int REFRESH    = 100_000,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  tick,
  output logic                  wrap
);

  localparam int   PW  = $clog2(PRESCALE);
  localparam int   SW  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]     pre;
  logic              step;
  logic [DIGITS:0]   carry;
  logic [3:0]        digit_val [DIGITS];
  logic [SW-1:0]     scan;
  logic [IW-1:0]     idx;
  logic              all_zero;
  logic              blank;
  logic [7:0]        lit;
  logic [DIGITS-1:0] onehot;

  // A coincident clear wins over the step, so no tick/wrap is raised.
  assign step = en & ~clear & (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PW'(PRESCALE - 1)) ? '0 : pre + PW'(1);
    end
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .step      (step),
      .up        (up),
      .carry_in  (carry[g]),
      .value     (digit_val[g]),
      .carry_out (carry[g+1])
    );
    assign count_bcd[4*g +: 4] = digit_val[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= step & carry[DIGITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan <= '0;
      idx  <= '0;
    end else if (scan == SW'(REFRESH - 1)) begin
      scan <= '0;
      idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      scan <= scan + SW'(1);
    end
  end

  // Walk from the top digit down so all_zero means "this digit and all above are 0".
  always_comb begin
    all_zero = 1'b1;
    blank    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (digit_val[k] == 4'd0);
      if (IW'(k) == idx) blank = (BLANK_LZ != 0) && all_zero && (k != 0);
    end
    lit = {blank ? SEG_BLANK : seg_pattern(digit_val[idx]), (idx == '0) && !en};
  end

  assign onehot = DIGITS'(1) << idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg     <= drive_level(8'h00, INV);
      dig_sel <= {DIGITS{INV}};
    end else begin
      seg     <= drive_level(lit, INV);
      dig_sel <= onehot ^ {DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_bcd_counter_mux_display.sv
// Randomized bench for the BCD counter/display: a decimal reference model feeds a
// step scoreboard and per-cycle expectations for an active-high and an active-low DUT.
module tb_bcd_counter_mux_display;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int REFRESH  = 2;
  localparam int MAXC     = 100;

  localparam logic [6:0] PAT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  logic clk = 1'b0;
  logic rst, en, up, clear;
  logic [7:0] seg, seg_al;
  logic [1:0] dig_sel, dig_al;
  logic [7:0] count_bcd, count_al;
  logic tick, wrap, tick_al, wrap_al;

  always #5 clk = ~clk;

  bcd_counter_mux_display #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .REFRESH(REFRESH), .ACTIVE_LOW(0), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
    .seg(seg), .dig_sel(dig_sel), .count_bcd(count_bcd), .tick(tick), .wrap(wrap)
  );

  bcd_counter_mux_display #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .REFRESH(REFRESH), .ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut_al (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
    .seg(seg_al), .dig_sel(dig_al), .count_bcd(count_al), .tick(tick_al), .wrap(wrap_al)
  );

  int n_cmp = 0;
  int n_err = 0;

  int m_pre, m_cnt, m_n;
  logic exp_tick, exp_wrap;
  logic [7:0] exp_seg, exp_seg_al;
  logic [1:0] exp_dig, exp_dig_al;
  logic [8:0] sb [$];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs for the next rising edge and advance the reference model across it.
  task automatic cycle(input logic r, input logic e, input logic u, input logic c);
    int   di, dv;
    logic bl;
    rst = r; en = e; up = u; clear = c;
    exp_tick = 1'b0;
    exp_wrap = 1'b0;
    if (r) begin
      m_pre = 0; m_cnt = 0; m_n = 0;
      exp_seg = 8'h00;
      exp_dig = 2'b00;
    end else begin
      di = (m_n / REFRESH) % DIGITS;
      dv = (m_cnt / (10 ** di)) % 10;
      bl = (di > 0) && (m_cnt < 10 ** di);
      exp_dig = 2'(1 << di);
      exp_seg = {bl ? 7'h00 : PAT[dv], (di == 0) && !e};
      m_n++;
      if (c) begin
        m_pre = 0;
        m_cnt = 0;
      end else if (e) begin
        if (m_pre == PRESCALE - 1) begin
          m_pre    = 0;
          exp_wrap = u ? (m_cnt == MAXC - 1) : (m_cnt == 0);
          m_cnt    = u ? (m_cnt + 1) % MAXC : (m_cnt + MAXC - 1) % MAXC;
          exp_tick = 1'b1;
          sb.push_back({to_bcd(m_cnt), exp_wrap});
        end else begin
          m_pre++;
        end
      end
    end
    exp_seg_al = ~exp_seg;
    exp_dig_al = ~exp_dig;
    @(negedge clk);
  endtask

  // Monitor: per-cycle state checks plus scoreboard pops whenever the DUT ticks.
  initial begin
    logic [8:0] ent;
    forever begin
      @(posedge clk);
      #1;
      chk("count", count_bcd, to_bcd(m_cnt));
      chk("tick", tick, exp_tick);
      chk("wrap", wrap, exp_wrap);
      chk("seg", seg, exp_seg);
      chk("dig_sel", dig_sel, exp_dig);
      chk("seg_active_low", seg_al, exp_seg_al);
      chk("dig_sel_active_low", dig_al, exp_dig_al);
      if (tick) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected_tick: got tick=1 with count %0h, expected no step", count_bcd);
        end else begin
          ent = sb.pop_front();
          chk("sb_count", count_bcd, ent[8:1]);
          chk("sb_wrap", wrap, ent[0]);
        end
      end
    end
  end

  initial begin
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0);

    repeat (40) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ten_steps_0x10", count_bcd, 8'h10);

    for (int i = 0; i < 1000 && m_cnt != 99; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (PRESCALE) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_up_to_00", count_bcd, 8'h00);
    repeat (PRESCALE) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_down_to_99", count_bcd, 8'h99);

    for (int i = 0; i < 20 && m_pre != PRESCALE - 1; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clear_on_step_count", count_bcd, 8'h00);
    chk("clear_on_step_tick", tick, 1'b0);

    for (int i = 0; i < 100 && m_cnt != 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("pause_holds_05", count_bcd, 8'h05);

    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
    end

    for (int i = 0; i < 2000 && m_cnt != 37; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (1) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_mid_count", count_bcd, 8'h00);
    chk("rst_mid_dig_sel", dig_sel, 2'b00);
    chk("rst_mid_seg", seg, 8'h00);
    chk("rst_mid_tick", tick, 1'b0);
    repeat (12) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
